// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage pipelined floating-point add/subtract, round-to-nearest-even.
// Define FADD_PIPE_SUBNORMAL_EN for IEEE subnormals; the default build flushes them to signed zero.
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic                 sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int N      = MAN_W + 4;         // hidden + fraction + guard/round/sticky
    localparam int SW     = N + 1;             // plus carry-out
    localparam int LZW    = $clog2(SW + 1);
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam int STAGES = 3;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [STAGES:1] vld_pipe;
    logic            advance;

    assign out_valid = vld_pipe[STAGES];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // ---------------- stage 1: unpack, swap, align ----------------
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_big, sp1;
    logic [EXP_W-1:0] ea, eb, el, es, ed;
    logic [MAN_W:0]   ma, mb, ml, ms;
    logic [N-1:0]     ext_s, lost_mask, al;
    logic [W-1:0]     spv1;

    always_comb begin
        sa    = x1[W-1];
        sb    = x2[W-1] ^ sub;
        a_nan = (&x1[W-2:MAN_W]) && (|x1[MAN_W-1:0]);
        b_nan = (&x2[W-2:MAN_W]) && (|x2[MAN_W-1:0]);
        a_inf = (&x1[W-2:MAN_W]) && !(|x1[MAN_W-1:0]);
        b_inf = (&x2[W-2:MAN_W]) && !(|x2[MAN_W-1:0]);
`ifdef FADD_PIPE_SUBNORMAL_EN
        ea = (|x1[W-2:MAN_W]) ? x1[W-2:MAN_W] : EXP_W'(1);
        eb = (|x2[W-2:MAN_W]) ? x2[W-2:MAN_W] : EXP_W'(1);
        ma = {|x1[W-2:MAN_W], x1[MAN_W-1:0]};
        mb = {|x2[W-2:MAN_W], x2[MAN_W-1:0]};
`else
        ea = x1[W-2:MAN_W];
        eb = x2[W-2:MAN_W];
        ma = (|ea) ? {1'b1, x1[MAN_W-1:0]} : '0;
        mb = (|eb) ? {1'b1, x2[MAN_W-1:0]} : '0;
`endif
        a_big = {ea, ma} >= {eb, mb};
        el    = a_big ? ea : eb;
        es    = a_big ? eb : ea;
        ml    = a_big ? ma : mb;
        ms    = a_big ? mb : ma;
        ed    = el - es;
        // Shifts of N or more leave al empty and the mask full, so every bit lands in sticky.
        ext_s     = {ms, 3'b000};
        lost_mask = ~({N{1'b1}} << ed);
        al        = ext_s >> ed;
        al[0]     = al[0] | (|(ext_s & lost_mask));
        sp1       = a_nan || b_nan || a_inf || b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            spv1 = QNAN;
        else if (a_inf)
            spv1 = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            spv1 = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    logic [TAG_W-1:0] s1_tag;
    logic             s1_sp, s1_sign, s1_sub;
    logic [W-1:0]     s1_spv;
    logic [EXP_W-1:0] s1_exp;
    logic [N-1:0]     s1_ml, s1_ms;

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_tag  <= in_tag;
            s1_sp   <= sp1;
            s1_spv  <= spv1;
            s1_sign <= a_big ? sa : sb;
            s1_sub  <= sa ^ sb;
            s1_exp  <= el;
            s1_ml   <= {ml, 3'b000};
            s1_ms   <= al;
        end
    end

    // ---------------- stage 2: add/sub, leading-zero count ----------------
    logic [SW-1:0]  sum2;
    logic [LZW-1:0] lz2;

    always_comb begin
        sum2 = s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
        lz2  = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (sum2[i]) lz2 = LZW'(SW - 1 - i);
    end

    logic [TAG_W-1:0] s2_tag;
    logic             s2_sp, s2_sign, s2_sub;
    logic [W-1:0]     s2_spv;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;
    logic [LZW-1:0]   s2_lz;

    always_ff @(posedge clk) begin
        if (advance) begin
            s2_tag  <= s1_tag;
            s2_sp   <= s1_sp;
            s2_spv  <= s1_spv;
            s2_sign <= s1_sign;
            s2_sub  <= s1_sub;
            s2_exp  <= s1_exp;
            s2_sum  <= sum2;
            s2_lz   <= lz2;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    int             e3, sh3;
    logic [N-1:0]   norm;
    logic           rnd;
    logic [MAN_W+1:0] mant;
    logic [W-1:0]   res;

    always_comb begin
        e3  = int'(s2_exp);
        sh3 = 0;
        if (s2_sum[N]) begin
            norm = s2_sum[N:1] | N'(s2_sum[0]);
            e3   = e3 + 1;
        end else begin
            sh3 = int'(s2_lz) - 1;
`ifdef FADD_PIPE_SUBNORMAL_EN
            // Stop at exponent 1 so tiny results come out as subnormals.
            if (sh3 > e3 - 1) sh3 = e3 - 1;
`endif
            norm = s2_sum[N-1:0] << sh3;
            e3   = e3 - sh3;
        end
        rnd  = norm[2] && (norm[1] || norm[0] || norm[3]);
        mant = {1'b0, norm[N-1:3]} + (MAN_W+2)'(rnd);
        if (mant[MAN_W+1]) begin
            mant = mant >> 1;
            e3   = e3 + 1;
        end
        if (s2_sp)
            res = s2_spv;
        else if (s2_sum == '0)
            res = {s2_sign && !s2_sub, {(W-1){1'b0}}};
        else if (e3 >= EMAX)
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FADD_PIPE_SUBNORMAL_EN
        else
            res = {s2_sign, mant[MAN_W] ? EXP_W'(e3) : {EXP_W{1'b0}}, mant[MAN_W-1:0]};
`else
        else if (e3 < 1 || !mant[MAN_W])
            res = {s2_sign, {(W-1){1'b0}}};
        else
            res = {s2_sign, EXP_W'(e3), mant[MAN_W-1:0]};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_pipe <= '0;
            y        <= '0;
            out_tag  <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            y        <= res;
            out_tag  <= s2_tag;
        end
    end
endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: vector table plus stall and reset sequences.
module tb_fadd_pipe;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x1 = '0, x2 = '0;
    logic        sub = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic [3:0]  out_tag;

    fadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  tag;
        logic [31:0] exp_y;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

`ifdef FADD_PIPE_SUBNORMAL_EN
    localparam logic [31:0] TINY_SUM  = 32'h00000002;
    localparam logic [31:0] TINY_DIFF = 32'h00000001;
`else
    localparam logic [31:0] TINY_SUM  = 32'h00000000;
    localparam logic [31:0] TINY_DIFF = 32'h00000000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] tag, input logic [31:0] e);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.tag = tag; v.exp_y = e;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        x1 = v.a; x2 = v.b; sub = v.s; in_tag = v.tag; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency[%0d]", idx), 32'(lat), 32'd3);
        check($sformatf("y[%0d]", idx), y, v.exp_y);
        check($sformatf("tag[%0d]", idx), 32'(out_tag), 32'(v.tag));
    endtask

    logic [31:0] st_a [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000};
    logic [31:0] st_b [4] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h3F800000};
    logic        st_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] st_y [4] = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h3F800000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got;
        logic fire, holding;
        logic [31:0] hold_y;

        add(32'h3F800000, 32'h3F800000, 1'b0, 4'd5,  32'h40000000); // 1+1
        add(32'h3F800001, 32'h33800000, 1'b0, 4'd1,  32'h3F800002); // tie, round up to even
        add(32'h3F800000, 32'h33800000, 1'b0, 4'd2,  32'h3F800000); // tie, stays even
        add(32'h3F800000, 32'h33800001, 1'b0, 4'd3,  32'h3F800001); // above half ulp
        add(32'h7F800000, 32'h7F800000, 1'b1, 4'd4,  32'h7FC00000); // inf-inf
        add(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6,  32'h7F800000); // overflow
        add(32'h00000001, 32'h00000001, 1'b0, 4'd7,  TINY_SUM);
        add(32'h3F800000, 32'h3F800000, 1'b1, 4'd8,  32'h00000000); // exact cancel -> +0
        add(32'h80000000, 32'h80000000, 1'b0, 4'd9,  32'h80000000); // -0 + -0
        add(32'h3F800000, 32'hBF800000, 1'b0, 4'd10, 32'h00000000);
        add(32'h3FC00000, 32'h40100000, 1'b0, 4'd11, 32'h40700000); // 1.5+2.25
        add(32'h40400000, 32'h40000000, 1'b1, 4'd12, 32'h3F800000); // 3-2
        add(32'hC0000000, 32'h3F800000, 1'b0, 4'd13, 32'hBF800000); // -2+1
        add(32'h3F800000, 32'h00800000, 1'b1, 4'd14, 32'h3F800000); // far sticky on subtract
        add(32'h7FC00000, 32'h3F800000, 1'b0, 4'd15, 32'h7FC00000); // NaN in
        add(32'h7F800001, 32'h00000000, 1'b0, 4'd0,  32'h7FC00000); // sNaN in -> qNaN
        add(32'hFF800000, 32'h3F800000, 1'b0, 4'd1,  32'hFF800000); // -inf + finite
        add(32'h3F800000, 32'h7F800000, 1'b1, 4'd2,  32'hFF800000); // 1 - inf
        add(32'h00800001, 32'h00800000, 1'b1, 4'd3,  TINY_DIFF);    // below min normal

        // reset state
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // stall: 4 back-to-back beats, downstream blocked for 5 cycles once full
        sent = 0; got = 0; holding = 1'b0; hold_y = '0;
        @(negedge clk);
        for (int c = 0; c < 40 && got < 4; c++) begin
            in_valid = (sent < 4);
            if (sent < 4) begin
                x1 = st_a[sent]; x2 = st_b[sent]; sub = st_s[sent]; in_tag = 4'(sent + 1);
            end
            out_ready = (c >= 8);
            #1;
            if (c >= 3 && c < 8) begin
                check($sformatf("stall_in_ready[%0d]", c), 32'(in_ready), 32'd0);
                check($sformatf("stall_valid[%0d]", c), 32'(out_valid), 32'd1);
            end
            if (out_valid && !out_ready) begin
                if (holding) check($sformatf("stall_hold[%0d]", c), y, hold_y);
                hold_y  = y;
                holding = 1'b1;
            end
            if (out_valid && out_ready && got < 4) begin
                check($sformatf("drain_y[%0d]", got), y, st_y[got]);
                check($sformatf("drain_tag[%0d]", got), 32'(out_tag), 32'(got + 1));
                got++;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stall_sent", 32'(sent), 32'd4);
        check("stall_got", 32'(got), 32'd4);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("no_dup[%0d]", c), 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // reset with two beats in flight
        out_ready = 1'b1;
        x1 = 32'h3F800000; x2 = 32'h3F800000; sub = 1'b0; in_tag = 4'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_tag = 4'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", y, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("midrst_stale[%0d]", c), 32'(out_valid), 32'd0);
        end
        run_vec(vecs[0], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
